// File: rtl/noc_pkg.sv
// Port indices, up-port policy encodings and the route decode shared by
// the fat-tree switch nodes.
package noc_pkg;
  localparam int L     = 0;
  localparam int R     = 1;
  localparam int U0    = 2;
  localparam int U1    = 3;
  localparam int NPORT = 4;

  typedef enum int {
    UP_DET   = 0,
    UP_ADAPT = 1
  } up_mode_e;

  // Up-bound flits are flagged on the U0 bit; the node chooses the real up port.
  function automatic logic [NPORT-1:0] route_decode(input int addr, input int posl,
                                                    input int posx);
    logic [NPORT-1:0] dst;
    dst = '0;
    if ((addr >> (posl + 1)) == posx) begin
      if (addr[posl]) dst[R] = 1'b1;
      else            dst[L] = 1'b1;
    end else begin
      dst[U0] = 1'b1;
    end
    return dst;
  endfunction

  function automatic logic down_bit(input int addr, input int posl);
    return addr[posl];
  endfunction
endpackage

// File: rtl/route_fifo.sv
// Synchronous FIFO with full/empty flags; head word is readable while not empty.
module route_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;
  logic [PW:0]   cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_q];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
endmodule

// File: rtl/pi_route_buf.sv
// Buffered fat-tree switch node: per-input FIFOs, per-output round-robin
// arbiters and registered output slots with valid/backpressure.
module pi_route_buf
  import noc_pkg::*;
#(
  parameter int N       = 8,
  parameter int A_W     = $clog2(N),
  parameter int D_W     = 32,
  parameter int posl    = 0,
  parameter int posx    = 0,
  parameter int FIFO_D  = 4,
  parameter int UP_MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic [NPORT-1:0]     i_v,
  output logic [NPORT-1:0]     i_bp,
  input  logic [NPORT*A_W-1:0] i_addr,
  input  logic [NPORT*D_W-1:0] i_data,
  output logic [NPORT-1:0]     o_v,
  input  logic [NPORT-1:0]     o_bp,
  output logic [NPORT*A_W-1:0] o_addr,
  output logic [NPORT*D_W-1:0] o_data
);
  localparam int W = A_W + D_W;

  logic [NPORT-1:0] full, empty, push, pop, can_load, gnt;
  logic [A_W-1:0]   haddr [NPORT];
  logic [D_W-1:0]   hdata [NPORT];
  logic [NPORT-1:0] req   [NPORT];
  logic [1:0]       win   [NPORT];
  logic [1:0]       ptr_q [NPORT];
  logic [NPORT-1:0] o_v_q;
  logic [A_W-1:0]   o_addr_q [NPORT];
  logic [D_W-1:0]   o_data_q [NPORT];
  logic [NPORT-1:0] dst;
  logic [1:0]       idx;
  int               pref, alt;

  for (genvar gp = 0; gp < NPORT; gp++) begin : g_in
    logic [W-1:0] head;
    assign push[gp] = ce & i_v[gp] & ~full[gp];
    route_fifo #(.DEPTH(FIFO_D), .W(W)) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (push[gp]),
      .pop_i  (pop[gp]),
      .wdata_i({i_addr[gp*A_W +: A_W], i_data[gp*D_W +: D_W]}),
      .rdata_o(head),
      .full_o (full[gp]),
      .empty_o(empty[gp])
    );
    assign haddr[gp] = head[W-1 -: A_W];
    assign hdata[gp] = head[D_W-1:0];
  end

  assign i_bp     = ce ? full : '1;
  assign can_load = ~o_v_q | ~o_bp;

  // Each input raises exactly one request, so one grant per input per cycle follows.
  always_comb begin
    dst  = '0;
    pref = U0;
    alt  = U1;
    for (int o = 0; o < NPORT; o++) req[o] = '0;
    for (int p = 0; p < NPORT; p++) begin
      dst = '0;
      if (p >= U0) begin
        dst[down_bit(32'(haddr[p]), posl) ? R : L] = 1'b1;
      end else begin
        dst = route_decode(32'(haddr[p]), posl, posx);
        // A self-addressed down flit cannot U-turn; hand it upward instead.
        if (dst[p]) begin
          dst     = '0;
          dst[U0] = 1'b1;
        end
        if (dst[U0]) begin
          pref = (p == L) ? U0 : U1;
          alt  = (p == L) ? U1 : U0;
          dst  = '0;
          if (UP_MODE == int'(UP_ADAPT) && !can_load[pref] && can_load[alt]) dst[alt] = 1'b1;
          else dst[pref] = 1'b1;
        end
      end
      for (int o = 0; o < NPORT; o++) req[o][p] = dst[o] & ~empty[p];
    end
  end

  always_comb begin
    idx = '0;
    gnt = '0;
    pop = '0;
    for (int o = 0; o < NPORT; o++) begin
      win[o] = ptr_q[o];
      for (int k = 0; k < NPORT; k++) begin
        idx = ptr_q[o] + 2'(k);
        if (!gnt[o] && req[o][idx]) begin
          gnt[o] = 1'b1;
          win[o] = idx;
        end
      end
      gnt[o] = gnt[o] & ce & can_load[o];
      if (gnt[o]) pop[win[o]] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_v_q <= '0;
      for (int o = 0; o < NPORT; o++) begin
        ptr_q[o]    <= '0;
        o_addr_q[o] <= '0;
        o_data_q[o] <= '0;
      end
    end else if (ce) begin
      for (int o = 0; o < NPORT; o++) begin
        if (gnt[o]) begin
          o_v_q[o]    <= 1'b1;
          o_addr_q[o] <= haddr[win[o]];
          o_data_q[o] <= hdata[win[o]];
          ptr_q[o]    <= win[o] + 2'd1;
        end else if (!o_bp[o]) begin
          o_v_q[o] <= 1'b0;
        end
      end
    end
  end

  assign o_v = o_v_q;
  for (genvar go = 0; go < NPORT; go++) begin : g_out
    assign o_addr[go*A_W +: A_W] = o_addr_q[go];
    assign o_data[go*D_W +: D_W] = o_data_q[go];
  end
endmodule

// File: tb/tb_pi_route_buf.sv
// Bench for pi_route_buf: deterministic and adaptive instances share stimulus and
// are each compared every cycle against a queue-based reference model.
module tb_pi_route_buf;
  localparam int N = 8, A_W = 3, D_W = 32, FD = 4, POSL = 0, POSX = 0;
  localparam int W = A_W + D_W;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic ce;
  logic [3:0] i_v, o_bp;
  logic [4*A_W-1:0] i_addr;
  logic [4*D_W-1:0] i_data;
  logic [3:0] i_bp0, o_v0, i_bp1, o_v1;
  logic [4*A_W-1:0] o_addr0, o_addr1;
  logic [4*D_W-1:0] o_data0, o_data1;

  int n_checks = 0;
  int n_errors = 0;

  logic [W-1:0]   mq [8][$];
  bit             mv [2][4];
  logic [A_W-1:0] ma [2][4];
  logic [D_W-1:0] md [2][4];
  int             mptr [2][4];

  always #5 clk = ~clk;

  pi_route_buf #(.N(N), .A_W(A_W), .D_W(D_W), .posl(POSL), .posx(POSX), .FIFO_D(FD),
                 .UP_MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .i_v(i_v), .i_bp(i_bp0), .i_addr(i_addr),
    .i_data(i_data), .o_v(o_v0), .o_bp(o_bp), .o_addr(o_addr0), .o_data(o_data0));

  pi_route_buf #(.N(N), .A_W(A_W), .D_W(D_W), .posl(POSL), .posx(POSX), .FIFO_D(FD),
                 .UP_MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .ce(ce), .i_v(i_v), .i_bp(i_bp1), .i_addr(i_addr),
    .i_data(i_data), .o_v(o_v1), .o_bp(o_bp), .o_addr(o_addr1), .o_data(o_data1));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) mq[i].delete();
    for (int m = 0; m < 2; m++)
      for (int o = 0; o < 4; o++) begin
        mv[m][o] = 1'b0;
        mptr[m][o] = 0;
      end
  endtask

  // One clock edge of the node m (0 = deterministic, 1 = adaptive) from current inputs.
  task automatic model_step(input int m);
    int t[4];
    bit cl[4];
    bit full[4];
    int win, pref, ai, i;
    logic [W-1:0] h;
    if (!ce) return;
    for (int o = 0; o < 4; o++) cl[o] = !mv[m][o] || !o_bp[o];
    for (int p = 0; p < 4; p++) begin
      full[p] = (mq[m*4+p].size() == FD);
      t[p] = -1;
      if (mq[m*4+p].size() != 0) begin
        h  = mq[m*4+p][0];
        ai = int'(h[W-1 -: A_W]);
        if (p >= 2) t[p] = (ai >> POSL) & 1;
        else if ((ai >> (POSL + 1)) == POSX) t[p] = (ai >> POSL) & 1;
        else begin
          pref = (p == 0) ? 2 : 3;
          t[p] = (m == 1 && !cl[pref]) ? 5 - pref : pref;
        end
      end
    end
    for (int o = 0; o < 4; o++) begin
      win = -1;
      if (cl[o])
        for (int k = 0; k < 4; k++) begin
          i = (mptr[m][o] + k) % 4;
          if (win < 0 && t[i] == o) win = i;
        end
      if (win >= 0) begin
        h = mq[m*4+win].pop_front();
        mv[m][o] = 1'b1;
        ma[m][o] = h[W-1 -: A_W];
        md[m][o] = h[D_W-1:0];
        mptr[m][o] = (win + 1) % 4;
      end else if (!o_bp[o]) begin
        mv[m][o] = 1'b0;
      end
    end
    for (int p = 0; p < 4; p++)
      if (i_v[p] && !full[p]) mq[m*4+p].push_back({i_addr[p*A_W +: A_W], i_data[p*D_W +: D_W]});
  endtask

  task automatic check_outs(input int m);
    logic [3:0] ov, ibp, efull;
    logic [4*A_W-1:0] oa;
    logic [4*D_W-1:0] od;
    ov  = (m == 0) ? o_v0 : o_v1;
    ibp = (m == 0) ? i_bp0 : i_bp1;
    oa  = (m == 0) ? o_addr0 : o_addr1;
    od  = (m == 0) ? o_data0 : o_data1;
    for (int p = 0; p < 4; p++) efull[p] = (mq[m*4+p].size() == FD);
    chk($sformatf("m%0d_ibp", m), 64'(ibp), 64'(ce ? efull : 4'hF));
    for (int o = 0; o < 4; o++) begin
      chk($sformatf("m%0d_ov%0d", m, o), 64'(ov[o]), 64'(mv[m][o]));
      if (mv[m][o]) begin
        chk($sformatf("m%0d_oaddr%0d", m, o), 64'(oa[o*A_W +: A_W]), 64'(ma[m][o]));
        chk($sformatf("m%0d_odata%0d", m, o), 64'(od[o*D_W +: D_W]), 64'(md[m][o]));
      end
    end
  endtask

  task automatic cycle();
    model_step(0);
    model_step(1);
    @(posedge clk);
    #1;
    check_outs(0);
    check_outs(1);
  endtask

  task automatic set_in(input int p, input logic v, input logic [A_W-1:0] a,
                        input logic [D_W-1:0] d);
    i_v[p] = v;
    i_addr[p*A_W +: A_W] = a;
    i_data[p*D_W +: D_W] = d;
  endtask

  initial begin
    logic [7:0] prev_src;
    bit have_prev;
    logic [3:0] snap_v;
    logic [D_W-1:0] snap_d;
    logic [A_W-1:0] ra;
    ce = 1'b1; i_v = '0; o_bp = '0; i_addr = '0; i_data = '0;
    model_reset();
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov0", 64'(o_v0), 64'h0);
    chk("rst_ov1", 64'(o_v1), 64'h0);
    chk("rst_ibp0", 64'(i_bp0), 64'h0);
    chk("rst_oaddr0", 64'(o_addr0), 64'h0);
    chk("rst_odata0", 64'(o_data0[63:0]), 64'h0);
    rst_n = 1'b1;

    // Single flit L -> R, two-cycle latency
    set_in(0, 1'b1, 3'd1, 32'hA1);
    cycle();
    set_in(0, 1'b0, 3'd0, 32'h0);
    chk("t1_ov_early", 64'(o_v0[1]), 64'h0);
    cycle();
    chk("t1_ov", 64'(o_v0[1]), 64'h1);
    chk("t1_addr", 64'(o_addr0[A_W +: A_W]), 64'h1);
    chk("t1_data", 64'(o_data0[D_W +: D_W]), 64'hA1);
    chk("t1_ibp", 64'(i_bp0), 64'h0);
    cycle();

    // Backpressure on R fills slot + FIFO, then drains in order
    o_bp = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      set_in(0, 1'b1, 3'd1, 32'h200 + 32'(k));
      cycle();
    end
    set_in(0, 1'b0, 3'd0, 32'h0);
    chk("t2_ibp_full", 64'(i_bp0[0]), 64'h1);
    chk("t2_slot0", 64'(o_data0[D_W +: D_W]), 64'h200);
    o_bp = 4'b0000;
    for (int k = 1; k < 5; k++) begin
      cycle();
      chk("t2_ov", 64'(o_v0[1]), 64'h1);
      chk("t2_order", 64'(o_data0[D_W +: D_W]), 64'h200 + 64'(k));
    end
    cycle();
    chk("t2_empty", 64'(o_v0[1]), 64'h0);

    // U0 and U1 contend for L: grants alternate
    have_prev = 1'b0;
    prev_src = '0;
    for (int c = 0; c < 12; c++) begin
      set_in(2, 1'b1, 3'd0, 32'h3000 + 32'(c));
      set_in(3, 1'b1, 3'd0, 32'h3100 + 32'(c));
      cycle();
      if (o_v0[0]) begin
        if (have_prev) chk("t3_alt", 64'(o_data0[15:8] != prev_src), 64'h1);
        prev_src = o_data0[15:8];
        have_prev = 1'b1;
      end
    end
    i_v = '0;
    repeat (10) cycle();

    // Up policy with U0 occupied and backpressured
    o_bp = 4'b0100;
    set_in(0, 1'b1, 3'd6, 32'h4A);
    cycle();
    set_in(0, 1'b1, 3'd6, 32'h4B);
    cycle();
    set_in(0, 1'b0, 3'd0, 32'h0);
    cycle();
    chk("t4_adapt_ov_u1", 64'(o_v1[3]), 64'h1);
    chk("t4_adapt_d_u1", 64'(o_data1[3*D_W +: D_W]), 64'h4B);
    chk("t4_det_ov_u1", 64'(o_v0[3]), 64'h0);
    chk("t4_det_d_u0", 64'(o_data0[2*D_W +: D_W]), 64'h4A);
    repeat (2) cycle();
    chk("t4_det_hold", 64'(o_data0[2*D_W +: D_W]), 64'h4A);
    o_bp = 4'b0000;
    cycle();
    chk("t4_det_late", 64'(o_data0[2*D_W +: D_W]), 64'h4B);
    repeat (3) cycle();

    // Clock-enable freeze mid-stream
    for (int c = 0; c < 3; c++) begin
      set_in(0, 1'b1, 3'd1, 32'h500 + 32'(c));
      cycle();
    end
    snap_v = o_v0;
    snap_d = o_data0[D_W +: D_W];
    ce = 1'b0;
    for (int c = 3; c < 6; c++) begin
      set_in(0, 1'b1, 3'd1, 32'h500 + 32'(c));
      cycle();
      chk("t5_ibp0", 64'(i_bp0), 64'hF);
      chk("t5_ibp1", 64'(i_bp1), 64'hF);
      chk("t5_ov_frozen", 64'(o_v0), 64'(snap_v));
      chk("t5_od_frozen", 64'(o_data0[D_W +: D_W]), 64'(snap_d));
    end
    ce = 1'b1;
    for (int c = 6; c < 9; c++) begin
      set_in(0, 1'b1, 3'd1, 32'h500 + 32'(c));
      cycle();
    end
    set_in(0, 1'b0, 3'd0, 32'h0);
    repeat (6) cycle();

    // Asynchronous reset with flits buffered
    o_bp = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      set_in(0, 1'b1, 3'd1, 32'h600 + 32'(c));
      cycle();
    end
    set_in(0, 1'b0, 3'd0, 32'h0);
    cycle();
    chk("t6_pre_ov", 64'(o_v0[1]), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_async_ov0", 64'(o_v0), 64'h0);
    chk("t6_async_ov1", 64'(o_v1), 64'h0);
    model_reset();
    #2 rst_n = 1'b1;
    o_bp = 4'b0000;
    repeat (5) cycle();
    chk("t6_no_stale", 64'(o_v0 | o_v1), 64'h0);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      ce = ($urandom_range(0, 9) != 0);
      for (int p = 0; p < 4; p++) begin
        o_bp[p] = ($urandom_range(0, 9) < 3);
        ra = A_W'($urandom_range(0, N - 1));
        if (p < 2 && int'(ra) == p) ra = ra ^ 3'd1;
        set_in(p, $urandom_range(0, 9) < 6, ra, $urandom);
      end
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
